boundary_scroll_ctrl: RTL and testbench

// Sequences the river boundary memory: accumulates per-frame scroll speed, toggles the

---
 rtl/boundary_scroll_ctrl.sv | 149 ++++++++++++++
 tb/tb_boundary_scroll_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/boundary_scroll_ctrl.sv
// River boundary sequencer: scroll accumulation, shift toggling, LFSR row generation and
// shared read-port arbitration (display > collision) in front of boundary_mem.
module boundary_scroll_ctrl #(
  parameter int          ADDR_W    = 9,
  parameter int          ROW_W     = 40,
  parameter int          RD_LAT    = 2,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          STEP      = 2,
  parameter int          LEFT_MIN  = 16,
  parameter int          RIGHT_MAX = 623,
  parameter int          MIN_GAP   = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              scroll_en,
  input  logic [4:0]        speed,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_valid,
  output logic [ROW_W-1:0]  disp_data,
  input  logic              col_req,
  input  logic [ADDR_W-1:0] col_addr,
  output logic              col_gnt,
  output logic              col_valid,
  output logic [ROW_W-1:0]  col_data,
  output logic [ADDR_W-1:0] mem_readaddress,
  input  logic [ROW_W-1:0]  mem_dataout,
  output logic              mem_shift,
  output logic [ROW_W-1:0]  mem_datain,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, SHIFT, SETTLE, GEN} state_t;

  localparam logic [ROW_W-1:0] ROW_RST = {10'd200, 10'd440, {(ROW_W-20){1'b0}}};

  state_t            state, state_nxt;
  logic [3:0]        acc;
  logic [1:0]        rows_left;
  logic [15:0]       lfsr, lfsr_nxt;
  logic [5:0]        sum;
  logic [RD_LAT-1:0] pipe_disp, pipe_col;
  logic              pipe_empty, rd_block;
  logic [10:0]       l_cur, r_cur, l_mv, r_mv, l_new, r_new;
  logic [ROW_W-1:0]  row_nxt;

  assign busy       = (state != IDLE);
  assign sum        = {2'b00, acc} + {1'b0, speed};
  assign pipe_empty = ~(|pipe_disp) & ~(|pipe_col);
  // Memory bases move between SHIFT and GEN, so reads are fenced off from DRAIN onward.
  assign rd_block   = (state == DRAIN) || (state == SHIFT) || (state == SETTLE) || (state == GEN);
  assign disp_gnt   = disp_req & ~rd_block;
  assign col_gnt    = col_req & ~busy & ~disp_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (frame_start && scroll_en) state_nxt = ACCUM;
      ACCUM: begin
        if (sum[5:4] == 2'd0)            state_nxt = IDLE;
        else if (pipe_empty && !disp_gnt) state_nxt = SHIFT;
        else                             state_nxt = DRAIN;
      end
      DRAIN:  if (pipe_empty) state_nxt = SHIFT;
      SHIFT:  state_nxt = SETTLE;
      SETTLE: state_nxt = GEN;
      GEN:    state_nxt = (rows_left > 2'd1) ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign l_cur    = {1'b0, mem_datain[ROW_W-1 -: 10]};
  assign r_cur    = {1'b0, mem_datain[ROW_W-11 -: 10]};

  always_comb begin
    l_mv = l_cur;
    r_mv = r_cur;
    case (lfsr_nxt[1:0])
      2'b00:   l_mv = l_cur - 11'(STEP);
      2'b10:   l_mv = l_cur + 11'(STEP);
      default: l_mv = l_cur;
    endcase
    case (lfsr_nxt[3:2])
      2'b00:   r_mv = r_cur - 11'(STEP);
      2'b10:   r_mv = r_cur + 11'(STEP);
      default: r_mv = r_cur;
    endcase
    l_new = (l_mv < 11'(LEFT_MIN))  ? 11'(LEFT_MIN)  : l_mv;
    r_new = (r_mv > 11'(RIGHT_MAX)) ? 11'(RIGHT_MAX) : r_mv;
    // A step that would pinch the channel below the minimum repeats the previous edges.
    if (r_new < l_new + 11'(MIN_GAP)) begin
      l_new = l_cur;
      r_new = r_cur;
    end
    row_nxt = {l_new[9:0], r_new[9:0], {(ROW_W-20){1'b0}}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc             <= 4'd0;
      rows_left       <= 2'd0;
      lfsr            <= SEED;
      mem_shift       <= 1'b0;
      mem_datain      <= ROW_RST;
      mem_readaddress <= '0;
      pipe_disp       <= '0;
      pipe_col        <= '0;
      disp_valid      <= 1'b0;
      col_valid       <= 1'b0;
      disp_data       <= '0;
      col_data        <= '0;
    end else begin
      if (state == ACCUM) begin
        acc       <= sum[3:0];
        rows_left <= sum[5:4];
      end
      if (state == SHIFT) mem_shift <= ~mem_shift;
      if (state == GEN) begin
        lfsr       <= lfsr_nxt;
        mem_datain <= row_nxt;
        rows_left  <= rows_left - 2'd1;
      end

      if (disp_gnt)     mem_readaddress <= disp_addr;
      else if (col_gnt) mem_readaddress <= col_addr;

      pipe_disp[0] <= disp_gnt;
      pipe_col[0]  <= col_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_disp[i] <= pipe_disp[i-1];
        pipe_col[i]  <= pipe_col[i-1];
      end

      disp_valid <= pipe_disp[RD_LAT-1];
      col_valid  <= pipe_col[RD_LAT-1];
      if (pipe_disp[RD_LAT-1]) disp_data <= mem_dataout;
      if (pipe_col[RD_LAT-1])  col_data  <= mem_dataout;
    end
  end

endmodule

// File: tb/tb_boundary_scroll_ctrl.sv
// Directed bench for boundary_scroll_ctrl with a one-cycle registered memory stand-in.
module tb_boundary_scroll_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0, scroll_en = 1'b0;
  logic [4:0]  speed = 5'd0;
  logic        disp_req = 1'b0, col_req = 1'b0;
  logic [8:0]  disp_addr = 9'd0, col_addr = 9'd0;
  logic        disp_gnt, disp_valid, col_gnt, col_valid;
  logic [39:0] disp_data, col_data, mem_dataout, mem_datain;
  logic [8:0]  mem_readaddress;
  logic        mem_shift, busy;

  int n_cmp = 0, n_err = 0;
  int tog_cnt = 0, busy_cnt = 0, dv_cnt = 0, cv_cnt = 0;
  logic sh_prev = 1'b0;

  int          m_l = 200, m_r = 440;
  logic [15:0] m_lfsr = 16'hACE1;

  boundary_scroll_ctrl dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .scroll_en(scroll_en), .speed(speed),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt), .disp_valid(disp_valid),
    .disp_data(disp_data), .col_req(col_req), .col_addr(col_addr), .col_gnt(col_gnt),
    .col_valid(col_valid), .col_data(col_data), .mem_readaddress(mem_readaddress),
    .mem_dataout(mem_dataout), .mem_shift(mem_shift), .mem_datain(mem_datain), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_dataout <= {31'h1234567, mem_readaddress};

  always @(negedge clk) begin
    if (mem_shift !== sh_prev) tog_cnt++;
    sh_prev = mem_shift;
    if (busy === 1'b1)       busy_cnt++;
    if (disp_valid === 1'b1) dv_cnt++;
    if (col_valid === 1'b1)  cv_cnt++;
  end

  function automatic logic [39:0] pat(input logic [8:0] a);
    return {31'h1234567, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_l = 200; m_r = 440; m_lfsr = 16'hACE1;
  endtask

  task automatic model_gen;
    int dl, dr, nl, nr;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    dl = (m_lfsr[1:0] == 2'b00) ? -2 : (m_lfsr[1:0] == 2'b10) ? 2 : 0;
    dr = (m_lfsr[3:2] == 2'b00) ? -2 : (m_lfsr[3:2] == 2'b10) ? 2 : 0;
    nl = m_l + dl; if (nl < 16)  nl = 16;
    nr = m_r + dr; if (nr > 623) nr = 623;
    if (nr - nl >= 128) begin
      m_l = nl; m_r = nr;
    end
  endtask

  function automatic logic [39:0] model_row();
    logic [9:0] l, r;
    l = m_l[9:0];
    r = m_r[9:0];
    return {l, r, 20'd0};
  endfunction

  task automatic run_frame(input logic [4:0] spd, input logic en, input int exp_rows, input string tag);
    int t0, b0;
    t0 = tog_cnt; b0 = busy_cnt;
    speed = spd; scroll_en = en; frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    repeat (12) tick;
    chk({tag, "_toggles"}, 64'(tog_cnt - t0), 64'(exp_rows));
    chk({tag, "_busy"}, 64'(busy_cnt - b0), en ? 64'(1 + 3 * exp_rows) : 64'd0);
    repeat (exp_rows) model_gen();
    chk({tag, "_datain"}, 64'(mem_datain), 64'(model_row()));
  endtask

  initial begin
    int d0, c0, t0, b0;
    logic [9:0] gl, gr;

    // Reset state
    repeat (3) tick;
    reset = 1'b0;
    chk("rst_shift", 64'(mem_shift), 64'd0);
    chk("rst_datain", 64'(mem_datain), 64'({10'd200, 10'd440, 20'd0}));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdaddr", 64'(mem_readaddress), 64'd0);
    chk("rst_ddata", 64'(disp_data), 64'd0);
    d0 = dv_cnt; c0 = cv_cnt;
    repeat (10) tick;
    chk("rst_no_dvalid", 64'(dv_cnt - d0), 64'd0);
    chk("rst_no_cvalid", 64'(cv_cnt - c0), 64'd0);

    // Simultaneous requests: display wins
    disp_req = 1'b1; disp_addr = 9'd5; col_req = 1'b1; col_addr = 9'd7;
    #1;
    chk("arb_disp_gnt", 64'(disp_gnt), 64'd1);
    chk("arb_col_gnt", 64'(col_gnt), 64'd0);
    c0 = cv_cnt;
    tick;
    disp_req = 1'b0; col_req = 1'b0;
    chk("arb_rdaddr", 64'(mem_readaddress), 64'd5);
    chk("arb_dvalid_early", 64'(disp_valid), 64'd0);
    tick;
    chk("arb_dvalid_early2", 64'(disp_valid), 64'd0);
    tick;
    chk("arb_dvalid", 64'(disp_valid), 64'd1);
    chk("arb_ddata", 64'(disp_data), 64'(pat(9'd5)));
    tick;
    chk("arb_dvalid_pulse", 64'(disp_valid), 64'd0);
    chk("arb_no_cvalid", 64'(cv_cnt - c0), 64'd0);

    // Collision-only read; display data must hold
    col_req = 1'b1; col_addr = 9'd7;
    #1;
    chk("col_gnt_idle", 64'(col_gnt), 64'd1);
    tick;
    col_req = 1'b0;
    repeat (2) tick;
    chk("col_valid", 64'(col_valid), 64'd1);
    chk("col_data", 64'(col_data), 64'(pat(9'd7)));
    chk("ddata_held", 64'(disp_data), 64'(pat(9'd5)));

    // Reset with a read in flight
    disp_req = 1'b1; disp_addr = 9'd3;
    tick;
    disp_req = 1'b0;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    d0 = dv_cnt;
    repeat (5) tick;
    chk("rst_inflight_no_valid", 64'(dv_cnt - d0), 64'd0);
    model_reset();

    // Scroll accumulation
    run_frame(5'd16, 1'b1, 1, "s16_f1");
    run_frame(5'd16, 1'b1, 1, "s16_f2");
    run_frame(5'd16, 1'b1, 1, "s16_f3");
    run_frame(5'd8, 1'b1, 0, "s8_f1");
    run_frame(5'd8, 1'b1, 1, "s8_f2");
    run_frame(5'd8, 1'b1, 0, "s8_f3");
    run_frame(5'd8, 1'b1, 1, "s8_f4");
    run_frame(5'd8, 1'b1, 0, "s8_f5");
    run_frame(5'd8, 1'b1, 1, "s8_f6");
    run_frame(5'd15, 1'b1, 0, "s15");
    run_frame(5'd31, 1'b1, 2, "s31_two_rows");
    run_frame(5'd31, 1'b0, 0, "scroll_off");

    // Collision held across a scroll (acc=14, speed 16 -> one row); frame_start in SHIFT ignored
    t0 = tog_cnt; b0 = busy_cnt;
    speed = 5'd16; scroll_en = 1'b1; frame_start = 1'b1;
    tick;
    col_req = 1'b1; col_addr = 9'd9;
    for (int k = 0; k < 5; k++) begin
      frame_start = (k == 1);
      #1;
      chk($sformatf("col_hold_k%0d", k), 64'(col_gnt), (k < 4) ? 64'd0 : 64'd1);
      tick;
    end
    col_req = 1'b0; frame_start = 1'b0;
    repeat (2) tick;
    chk("col_hold_valid", 64'(col_valid), 64'd1);
    chk("col_hold_data", 64'(col_data), 64'(pat(9'd9)));
    repeat (6) tick;
    chk("busy_frame_ignored", 64'(tog_cnt - t0), 64'd1);
    chk("col_hold_busy", 64'(busy_cnt - b0), 64'd4);
    model_gen();
    chk("col_hold_datain", 64'(mem_datain), 64'(model_row()));

    // Long run of generated rows: exact rows and minimum channel width
    for (int f = 0; f < 80; f++) begin
      run_frame(5'd16, 1'b1, 1, $sformatf("gen%0d", f));
      gl = mem_datain[39:30];
      gr = mem_datain[29:20];
      chk($sformatf("gap%0d", f), 64'(gr >= gl + 10'd128), 64'd1);
    end

    // Reset during SHIFT
    speed = 5'd16; scroll_en = 1'b1; frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    tick;
    #2 reset = 1'b1;
    #1;
    chk("rst_shift_busy", 64'(busy), 64'd0);
    chk("rst_shift_level", 64'(mem_shift), 64'd0);
    tick;
    reset = 1'b0;
    chk("rst_shift_datain", 64'(mem_datain), 64'({10'd200, 10'd440, 20'd0}));
    t0 = tog_cnt; b0 = busy_cnt;
    repeat (8) tick;
    chk("rst_shift_idle_tog", 64'(tog_cnt - t0), 64'd0);
    chk("rst_shift_idle_busy", 64'(busy_cnt - b0), 64'd0);
    model_reset();
    run_frame(5'd16, 1'b1, 1, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
